pipe_stage_skid_reg: RTL and testbench

//  Parametrised pipeline-stage register with valid/ready handshake and a 2-entry skid

---
 rtl/pipe_stage_skid_reg_if.sv | 20 ++
 rtl/pipe_stage_skid_reg.sv | 123 ++++++++++++
 tb/tb_pipe_stage_skid_reg.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/pipe_stage_skid_reg_if.sv
// pipe_stage_skid_reg_if: valid/ready handshake bundle carrying a PC and a payload
// Signals:
//   valid  producer has a live beat
//   ready  consumer can take the beat
//   pc     PC field of the beat
//   data   payload of the beat
// Modports:
//   master drives valid/pc/data and observes ready
//   slave  observes valid/pc/data and drives ready
interface pipe_stage_skid_reg_if #(
    parameter int DATA_W = 32,
    parameter int PC_W   = 32
);
    logic              valid;
    logic              ready;
    logic [PC_W-1:0]   pc;
    logic [DATA_W-1:0] data;
    modport master (output valid, output pc, output data, input ready);
    modport slave  (input valid, input pc, input data, output ready);
endinterface

// File: rtl/pipe_stage_skid_reg.sv
// pipe_stage_skid_reg: pipeline-stage register with valid/ready handshake, 2-entry skid, stall and flush
// Ports:
//   clk         rising-edge clock
//   reset       asynchronous active-low reset (0 = reset)
//   stall       freezes the output side (no issue)
//   flush       kills all entries and drives a bubble
//   up          upstream handshake (slave side): valid/pc/data in, registered ready out
//   dn          downstream handshake (master side): valid/pc/data out, ready in
//   stall_cnt   cycles with a live output held by stall     (PIPE_STAGE_PERF_EN only)
//   bubble_cnt  cycles with no live output, outside reset   (PIPE_STAGE_PERF_EN only)
// Build option: define PIPE_STAGE_PERF_EN to add the performance counters.
module pipe_stage_skid_reg #(
    parameter int                DATA_W      = 32,
    parameter int                PC_W        = 32,
    parameter logic [DATA_W-1:0] BUBBLE_DATA = DATA_W'(32'h00000013),
    parameter logic [DATA_W-1:0] RESET_DATA  = '0
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           stall,
    input  logic                           flush,
    pipe_stage_skid_reg_if.slave           up,
    pipe_stage_skid_reg_if.master          dn
`ifdef PIPE_STAGE_PERF_EN
    ,
    output logic [31:0]                    stall_cnt,
    output logic [31:0]                    bubble_cnt
`endif
);
    typedef enum logic [1:0] {EMPTY, ONE, FULL} state_t;
    state_t            state_q, state_d;
    logic              in_ready_q, in_ready_d;
    logic [PC_W-1:0]   main_pc_q, main_pc_d, skid_pc_q, skid_pc_d;
    logic [DATA_W-1:0] main_data_q, main_data_d, skid_data_q, skid_data_d;
    // remembers whether the last idle value was a flush bubble or the reset value
    logic              idle_bubble_q, idle_bubble_d;
    logic              accept, issue;
    assign accept    = up.valid & in_ready_q;
    assign issue     = (state_q != EMPTY) & dn.ready & ~stall;
    assign up.ready  = in_ready_q;
    assign dn.valid  = state_q != EMPTY;
    assign dn.pc     = main_pc_q;
    assign dn.data   = main_data_q;
    always_comb begin
        state_d       = state_q;
        main_pc_d     = main_pc_q;
        main_data_d   = main_data_q;
        skid_pc_d     = skid_pc_q;
        skid_data_d   = skid_data_q;
        idle_bubble_d = idle_bubble_q;
        if (flush) begin
            state_d       = EMPTY;
            main_pc_d     = '0;
            main_data_d   = BUBBLE_DATA;
            idle_bubble_d = 1'b1;
        end else begin
            case (state_q)
                EMPTY: if (accept) begin
                    state_d     = ONE;
                    main_pc_d   = up.pc;
                    main_data_d = up.data;
                end
                ONE: if (accept && issue) begin
                    main_pc_d   = up.pc;
                    main_data_d = up.data;
                end else if (accept) begin
                    state_d     = FULL;
                    skid_pc_d   = up.pc;
                    skid_data_d = up.data;
                end else if (issue) begin
                    // draining to empty restores the idle value so no live data lingers
                    state_d     = EMPTY;
                    main_pc_d   = '0;
                    main_data_d = idle_bubble_q ? BUBBLE_DATA : RESET_DATA;
                end
                FULL: if (issue) begin
                    state_d     = ONE;
                    main_pc_d   = skid_pc_q;
                    main_data_d = skid_data_q;
                end
                default: state_d = EMPTY;
            endcase
        end
        in_ready_d = state_d != FULL;
    end
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= EMPTY;
            in_ready_q    <= 1'b1;
            main_pc_q     <= '0;
            main_data_q   <= RESET_DATA;
            skid_pc_q     <= '0;
            skid_data_q   <= '0;
            idle_bubble_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            in_ready_q    <= in_ready_d;
            main_pc_q     <= main_pc_d;
            main_data_q   <= main_data_d;
            skid_pc_q     <= skid_pc_d;
            skid_data_q   <= skid_data_d;
            idle_bubble_q <= idle_bubble_d;
        end
    end
`ifdef PIPE_STAGE_PERF_EN
    logic [31:0] stall_cnt_q, stall_cnt_d, bubble_cnt_q, bubble_cnt_d;
    always_comb begin
        stall_cnt_d  = stall_cnt_q + {31'd0, (state_q != EMPTY) & stall};
        bubble_cnt_d = bubble_cnt_q + {31'd0, state_q == EMPTY};
    end
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_cnt_q  <= '0;
            bubble_cnt_q <= '0;
        end else begin
            stall_cnt_q  <= stall_cnt_d;
            bubble_cnt_q <= bubble_cnt_d;
        end
    end
    assign stall_cnt  = stall_cnt_q;
    assign bubble_cnt = bubble_cnt_q;
`endif
endmodule

// File: tb/tb_pipe_stage_skid_reg.sv
// tb_pipe_stage_skid_reg: directed self-checking bench for pipe_stage_skid_reg
module tb_pipe_stage_skid_reg;
    logic clk = 1'b0;
    logic reset = 1'b0;
    logic stall = 1'b0;
    logic flush = 1'b0;
    int checks = 0;
    int errors = 0;
    int issued = 0;
    int base;
    pipe_stage_skid_reg_if #(.DATA_W(32), .PC_W(32)) up_if ();
    pipe_stage_skid_reg_if #(.DATA_W(32), .PC_W(32)) dn_if ();
`ifdef PIPE_STAGE_PERF_EN
    logic [31:0] stall_cnt, bubble_cnt;
`endif
    pipe_stage_skid_reg dut (
        .clk(clk),
        .reset(reset),
        .stall(stall),
        .flush(flush),
        .up(up_if),
        .dn(dn_if)
`ifdef PIPE_STAGE_PERF_EN
        ,
        .stall_cnt(stall_cnt),
        .bubble_cnt(bubble_cnt)
`endif
    );
    always #5 clk = ~clk;
    always @(posedge clk)
        if (reset && dn_if.valid && dn_if.ready && !stall) issued <= issued + 1;
    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask
    task automatic push(input logic v, input logic [31:0] pc, input logic [31:0] data);
        up_if.valid = v;
        up_if.pc    = pc;
        up_if.data  = data;
    endtask
    initial begin
        push(1'b0, 32'h0, 32'h0);
        dn_if.ready = 1'b0;
        tick();
        tick();
        chk("rst_valid", dn_if.valid, 0);
        chk("rst_ready", up_if.ready, 1);
        chk("rst_data", dn_if.data, 0);
        chk("rst_pc", dn_if.pc, 0);
        reset = 1'b1;
        tick();
        chk("idle_valid", dn_if.valid, 0);
        // streaming, one cycle latency, full throughput
        dn_if.ready = 1'b1;
        push(1'b1, 32'h100, 32'h00500093);
        tick();
        chk("s1_valid", dn_if.valid, 1);
        chk("s1_pc", dn_if.pc, 32'h100);
        chk("s1_data", dn_if.data, 32'h00500093);
        chk("s1_ready", up_if.ready, 1);
        push(1'b1, 32'h104, 32'h00600113);
        tick();
        chk("s2_valid", dn_if.valid, 1);
        chk("s2_pc", dn_if.pc, 32'h104);
        chk("s2_data", dn_if.data, 32'h00600113);
        chk("s2_ready", up_if.ready, 1);
        push(1'b0, 32'h0, 32'h0);
        tick();
        chk("s_drain_valid", dn_if.valid, 0);
        chk("s_drain_data", dn_if.data, 0);
        chk("s_drain_pc", dn_if.pc, 0);
        chk("s_issued", issued, 2);
        // backpressure fills the skid, then drains in order
        dn_if.ready = 1'b0;
        push(1'b1, 32'h200, 32'hAAAA0001);
        tick();
        chk("bp1_pc", dn_if.pc, 32'h200);
        chk("bp1_ready", up_if.ready, 1);
        push(1'b1, 32'h204, 32'hAAAA0002);
        tick();
        chk("bp2_pc", dn_if.pc, 32'h200);
        chk("bp2_ready", up_if.ready, 0);
        push(1'b1, 32'h208, 32'hAAAA0003);
        tick();
        chk("bp3_pc", dn_if.pc, 32'h200);
        chk("bp3_ready", up_if.ready, 0);
        dn_if.ready = 1'b1;
        tick();
        chk("dr1_pc", dn_if.pc, 32'h204);
        chk("dr1_data", dn_if.data, 32'hAAAA0002);
        chk("dr1_ready", up_if.ready, 1);
        tick();
        chk("dr2_pc", dn_if.pc, 32'h208);
        chk("dr2_data", dn_if.data, 32'hAAAA0003);
        push(1'b0, 32'h0, 32'h0);
        tick();
        chk("dr3_valid", dn_if.valid, 0);
        chk("dr_issued", issued, 5);
        // stall holds a live entry, then issues it once
        push(1'b1, 32'h108, 32'h00700193);
        tick();
        push(1'b0, 32'h0, 32'h0);
        stall = 1'b1;
        base = issued;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("st_valid", dn_if.valid, 1);
            chk("st_pc", dn_if.pc, 32'h108);
            chk("st_data", dn_if.data, 32'h00700193);
        end
        chk("st_noissue", issued - base, 0);
        stall = 1'b0;
        tick();
        chk("st_rel_valid", dn_if.valid, 0);
        tick();
        chk("st_once", issued - base, 1);
        // stall still allows accept; flush beats stall and accept
        dn_if.ready = 1'b0;
        stall = 1'b1;
        push(1'b1, 32'h300, 32'hBBBB0001);
        tick();
        push(1'b1, 32'h304, 32'hBBBB0002);
        tick();
        chk("fl_full", up_if.ready, 0);
        chk("fl_pre_pc", dn_if.pc, 32'h300);
        flush = 1'b1;
        push(1'b1, 32'h308, 32'hDEADBEEF);
        tick();
        chk("fl_valid", dn_if.valid, 0);
        chk("fl_data", dn_if.data, 32'h00000013);
        chk("fl_pc", dn_if.pc, 0);
        chk("fl_ready", up_if.ready, 1);
        flush = 1'b0;
        stall = 1'b0;
        push(1'b0, 32'h0, 32'h0);
        dn_if.ready = 1'b1;
        base = issued;
        tick();
        tick();
        chk("fl_gone", dn_if.valid, 0);
        chk("fl_noissue", issued - base, 0);
        push(1'b1, 32'h400, 32'h12345678);
        tick();
        chk("post_fl_data", dn_if.data, 32'h12345678);
        push(1'b0, 32'h0, 32'h0);
        tick();
        chk("post_fl_idle", dn_if.data, 32'h00000013);
        // asynchronous reset with a full stage and a third beat waiting
        dn_if.ready = 1'b0;
        push(1'b1, 32'h500, 32'hCCCC0001);
        tick();
        push(1'b1, 32'h504, 32'hCCCC0002);
        tick();
        push(1'b1, 32'h508, 32'hCCCC0003);
        tick();
        chk("ar_pre_ready", up_if.ready, 0);
        chk("ar_pre_data", dn_if.data, 32'hCCCC0001);
        reset = 1'b0;
        #1;
        chk("ar_valid", dn_if.valid, 0);
        chk("ar_ready", up_if.ready, 1);
        chk("ar_data", dn_if.data, 0);
        chk("ar_pc", dn_if.pc, 0);
        push(1'b0, 32'h0, 32'h0);
        tick();
`ifdef PIPE_STAGE_PERF_EN
        reset = 1'b1;
        tick();
        tick();
        push(1'b1, 32'h600, 32'h1);
        tick();
        push(1'b0, 32'h0, 32'h0);
        dn_if.ready = 1'b1;
        stall = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        chk("pf_stall", stall_cnt, 5);
        chk("pf_bubble", bubble_cnt, 3);
        force dut.stall_cnt_q = 32'hFFFFFFFF;
        #1;
        release dut.stall_cnt_q;
        tick();
        chk("pf_wrap", stall_cnt, 0);
        stall = 1'b0;
        tick();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
